// File: rtl/arb_txn_ctrl_if.sv
// Command/response bus between the transaction controller and its single target.
// master = controller side, slave = target side.
interface arb_txn_ctrl_if #(
    parameter int IW = 1,
    parameter int DW = 8
) ();
    logic          bus_valid;
    logic          bus_ready;
    logic [IW-1:0] bus_id;
    logic [DW-1:0] bus_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    modport master (
        output bus_valid,
        output bus_id,
        output bus_wdata,
        input  bus_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  bus_valid,
        input  bus_id,
        input  bus_wdata,
        output bus_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/arb_txn_ctrl.sv
// Serves the arbiter's winner: issues one command, waits for the response
// (bounded by TIMEOUT), returns it with done and pulses ack to advance the arbiter.
module arb_txn_ctrl #(
    parameter int N       = 2,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15,
    parameter int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        grant,
    input  logic [N*DW-1:0]     req_data,
    output logic                ack,
    output logic                busy,
    arb_txn_ctrl_if.master      bus,
    output logic [N-1:0]        done,
    output logic [DW-1:0]       done_data,
    output logic                timeout,
    output logic                grant_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        ACK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          valid_q;
    logic [IW-1:0] id_q;
    logic [DW-1:0] wdata_q;

    logic [IW-1:0] idx;
    logic [DW-1:0] sel_data;
    logic          multi;

    // Lowest set grant bit wins, so an illegal multi-hot grant is still served.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (grant[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign sel_data = req_data[idx*DW +: DW];
    assign multi    = |(grant & (grant - N'(1)));

    assign bus.bus_valid = valid_q;
    assign bus.bus_id    = id_q;
    assign bus.bus_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            wdata_q   <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            done      <= '0;
            done_data <= '0;
            timeout   <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            ack  <= 1'b0;
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        id_q    <= idx;
                        wdata_q <= sel_data;
                        valid_q <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                        if (multi) begin
                            grant_err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (valid_q && bus.bus_ready) begin
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        state   <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A response arriving in the expiry cycle still wins.
                    if (bus.rsp_valid) begin
                        done_data <= bus.rsp_data;
                        timeout   <= 1'b0;
                        ack       <= 1'b1;
                        done      <= N'(1) << id_q;
                        state     <= ACK;
                    end else if (cnt == LAST) begin
                        done_data <= '0;
                        timeout   <= 1'b1;
                        ack       <= 1'b1;
                        done      <= N'(1) << id_q;
                        state     <= ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_txn_ctrl.sv
// Scenario bench for arb_txn_ctrl with a behavioural round-robin arbiter
// and a scoreboard of expected completions.
module tb_arb_txn_ctrl;

    localparam int N       = 2;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;
    localparam int IW      = 1;

    typedef struct {
        logic [N-1:0]  done;
        logic [DW-1:0] data;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  grant;
    logic [N-1:0]  grant_drv;
    logic [N*DW-1:0] req_data;
    logic          ack;
    logic          busy;
    logic [N-1:0]  done;
    logic [DW-1:0] done_data;
    logic          timeout;
    logic          grant_err;

    logic          use_arb;
    logic [N-1:0]  req;
    logic          ptr;
    logic [N-1:0]  arb_grant;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;

    arb_txn_ctrl_if #(.IW(IW), .DW(DW)) bif ();

    arb_txn_ctrl #(
        .N(N),
        .DW(DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .grant(grant),
        .req_data(req_data),
        .ack(ack),
        .busy(busy),
        .bus(bif),
        .done(done),
        .done_data(done_data),
        .timeout(timeout),
        .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    // Round-robin arbiter: pointer moves past the winner when ack falls.
    always_comb begin
        arb_grant = '0;
        if (ptr == 1'b0) begin
            if (req[0]) arb_grant = 2'b01;
            else if (req[1]) arb_grant = 2'b10;
        end else begin
            if (req[1]) arb_grant = 2'b10;
            else if (req[0]) arb_grant = 2'b01;
        end
    end

    always_comb grant = use_arb ? arb_grant : grant_drv;

    always_ff @(posedge clk) begin
        if (rst) ptr <= 1'b0;
        else if (ack) ptr <= ~bif.bus_id[0];
    end

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_ack: done=%b data=%h to=%b, expected no ack",
                         done, done_data, timeout);
            end else begin
                mon_e = sb.pop_front();
                if (done !== mon_e.done || done_data !== mon_e.data || timeout !== mon_e.to) begin
                    fails++;
                    $display("FAIL sb_completion: got done=%b data=%h to=%b, expected done=%b data=%h to=%b",
                             done, done_data, timeout, mon_e.done, mon_e.data, mon_e.to);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs WAIT_RSP cycles from cycle first_k; returns the cycle index where ack is seen.
    task automatic wait_ack(input int first_k, input int rsp_cycle,
                            input logic [DW-1:0] d, output int got);
        got = 0;
        for (int k = first_k; k <= 40; k++) begin
            bif.rsp_valid = (k == rsp_cycle);
            bif.rsp_data  = d;
            @(negedge clk);
            if (ack === 1'b1) begin
                got = k;
                break;
            end
            tick();
        end
        bif.rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        tests++;
        if ({ack, busy, bif.bus_valid, done, timeout, grant_err} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b, expected 0000000",
                     {ack, busy, bif.bus_valid, done, timeout, grant_err});
        end
        tests++;
        if ({bif.bus_id, bif.bus_wdata, done_data} !== 17'h0) begin
            fails++;
            $display("FAIL reset_data: got id=%h wdata=%h dd=%h, expected 0",
                     bif.bus_id, bif.bus_wdata, done_data);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        grant_drv     = 2'b01;
        req_data[7:0] = 8'hA5;
        bif.bus_ready = 1'b1;
        sb.push_back('{2'b01, 8'h3C, 1'b0});
        tick();
        grant_drv = '0;
        @(negedge clk);
        tests++;
        if (bif.bus_valid !== 1'b1 || bif.bus_wdata !== 8'hA5 || bif.bus_id !== 1'b0) begin
            fails++;
            $display("FAIL single_issue: got v=%b wd=%h id=%h, expected v=1 wd=a5 id=0",
                     bif.bus_valid, bif.bus_wdata, bif.bus_id);
        end
        tick();
        bif.rsp_valid = 1'b1;
        bif.rsp_data  = 8'h3C;
        @(negedge clk);
        tests++;
        if (bif.bus_valid !== 1'b0 || busy !== 1'b1 || ack !== 1'b0) begin
            fails++;
            $display("FAIL single_wait: got v=%b busy=%b ack=%b, expected v=0 busy=1 ack=0",
                     bif.bus_valid, busy, ack);
        end
        tick();
        bif.rsp_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (ack !== 1'b1 || done !== 2'b01 || done_data !== 8'h3C || timeout !== 1'b0) begin
            fails++;
            $display("FAIL single_ack: got ack=%b done=%b dd=%h to=%b, expected 1 01 3c 0",
                     ack, done, done_data, timeout);
        end
        tick();
        @(negedge clk);
        tests++;
        if (ack !== 1'b0 || done !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: got ack=%b done=%b busy=%b, expected 0 00 0",
                     ack, done, busy);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        int got;
        grant_drv     = 2'b01;
        req_data[7:0] = 8'hC3;
        bif.bus_ready = 1'b0;
        sb.push_back('{2'b01, 8'h11, 1'b0});
        tick();
        grant_drv     = '0;
        req_data[7:0] = 8'h00;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) bif.bus_ready = 1'b1;
            @(negedge clk);
            if (bif.bus_valid !== (i < 6)) bad++;
            if (i < 6 && (bif.bus_wdata !== 8'hC3 || bif.bus_id !== 1'b0)) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_valid_hold: got %0d bad cycles, expected 0", bad);
        end
        wait_ack(2, 14, 8'h11, got);
        tests++;
        if (got != 15 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_issue_count: got ack cycle %0d to=%b, expected 15 to=0",
                     got, timeout);
        end
        tick();
    endtask

    task automatic test_timeout(input int rsp_cycle);
        int got;
        int exp_k;
        grant_drv      = 2'b10;
        req_data[15:8] = 8'h5A;
        bif.bus_ready  = 1'b1;
        if (rsp_cycle != 0) sb.push_back('{2'b10, 8'h77, 1'b0});
        else sb.push_back('{2'b10, 8'h00, 1'b1});
        exp_k = (rsp_cycle != 0) ? rsp_cycle + 1 : TIMEOUT + 1;
        tick();
        grant_drv = '0;
        tick();
        wait_ack(1, rsp_cycle, 8'h77, got);
        tests++;
        if (got != exp_k) begin
            fails++;
            $display("FAIL timeout_cycle(rsp=%0d): got ack cycle %0d, expected %0d",
                     rsp_cycle, got, exp_k);
        end
        tests++;
        if (done !== 2'b10 || timeout !== (rsp_cycle == 0)
            || done_data !== ((rsp_cycle != 0) ? 8'h77 : 8'h00)) begin
            fails++;
            $display("FAIL timeout_result(rsp=%0d): got done=%b to=%b dd=%h",
                     rsp_cycle, done, timeout, done_data);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int n_iss = 0;
        int n_ack = 0;
        int n_resp = 0;
        int last_ack = -10;
        int id_bad = 0;
        int gap_bad = 0;
        logic resp_next = 1'b0;
        sb.push_back('{2'b01, 8'h90, 1'b0});
        sb.push_back('{2'b10, 8'h91, 1'b0});
        sb.push_back('{2'b01, 8'h92, 1'b0});
        req_data      = 16'h2110;
        bif.bus_ready = 1'b1;
        use_arb       = 1'b1;
        req           = 2'b11;
        for (int c = 0; c < 60 && n_ack < 3; c++) begin
            @(negedge clk);
            if (bif.bus_valid === 1'b1) begin
                if (bif.bus_id !== 1'(n_iss % 2)) id_bad++;
                if (bif.bus_wdata !== ((n_iss % 2 == 1) ? 8'h21 : 8'h10)) id_bad++;
                if (n_iss > 0 && c - last_ack != 2) gap_bad++;
                n_iss++;
                if (n_iss == 3) req = 2'b00;
                resp_next = 1'b1;
            end
            if (ack === 1'b1) begin
                n_ack++;
                last_ack = c;
            end
            tick();
            bif.rsp_valid = resp_next;
            bif.rsp_data  = 8'h90 + 8'(n_resp);
            if (resp_next) n_resp++;
            resp_next = 1'b0;
        end
        bif.rsp_valid = 1'b0;
        use_arb       = 1'b0;
        tests++;
        if (n_ack != 3 || n_iss != 3) begin
            fails++;
            $display("FAIL rr_count: got %0d issues %0d acks, expected 3 3", n_iss, n_ack);
        end
        tests++;
        if (id_bad != 0) begin
            fails++;
            $display("FAIL rr_order: got %0d wrong id/data, expected 0", id_bad);
        end
        tests++;
        if (gap_bad != 0) begin
            fails++;
            $display("FAIL rr_gap: got %0d wrong ACK-to-ISSUE gaps, expected 0", gap_bad);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        grant_drv     = 2'b01;
        req_data[7:0] = 8'hEE;
        bif.bus_ready = 1'b1;
        tick();
        grant_drv = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({ack, busy, bif.bus_valid, done, timeout} !== 6'b0
            || {bif.bus_id, bif.bus_wdata, done_data} !== 17'h0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got ack=%b busy=%b v=%b done=%b id=%h wd=%h dd=%h, expected 0",
                     ack, busy, bif.bus_valid, done, bif.bus_id, bif.bus_wdata, done_data);
        end
        tick();
        bif.rsp_valid = 1'b1;
        bif.rsp_data  = 8'hDD;
        tick();
        bif.rsp_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ack !== 1'b0 || done !== 2'b00 || busy !== 1'b0) seen++;
            tick();
        end
        tests++;
        if (seen != 0 || done_data !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid_stray: got %0d active cycles dd=%h, expected 0 00",
                     seen, done_data);
        end
    endtask

    task automatic test_illegal_grant();
        int got;
        grant_drv     = 2'b11;
        req_data      = 16'h4B3A;
        bif.bus_ready = 1'b1;
        sb.push_back('{2'b01, 8'h55, 1'b0});
        tick();
        grant_drv = '0;
        @(negedge clk);
        tests++;
        if (bif.bus_id !== 1'b0 || bif.bus_wdata !== 8'h3A || grant_err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_capture: got id=%h wd=%h err=%b, expected 0 3a 1",
                     bif.bus_id, bif.bus_wdata, grant_err);
        end
        tick();
        wait_ack(1, 1, 8'h55, got);
        tick();
        grant_drv = 2'b10;
        sb.push_back('{2'b10, 8'h66, 1'b0});
        tick();
        grant_drv = '0;
        tick();
        wait_ack(1, 1, 8'h66, got);
        tick();
        @(negedge clk);
        tests++;
        if (grant_err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_sticky: got err=%b, expected 1", grant_err);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (grant_err !== 1'b0) begin
            fails++;
            $display("FAIL illegal_clear: got err=%b, expected 0", grant_err);
        end
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        grant_drv     = '0;
        req_data      = '0;
        use_arb       = 1'b0;
        req           = '0;
        bif.bus_ready = 1'b0;
        bif.rsp_valid = 1'b0;
        bif.rsp_data  = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_timeout(0);
        test_timeout(15);
        test_round_robin();
        test_reset_mid();
        test_illegal_grant();
        repeat (3) tick();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending completions, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arb_txn_ctrl.md
# arb_txn_ctrl

Transaction controller sitting directly downstream of the round-robin request arbiter. It consumes the arbiter's one-hot `grant`, captures the winning requester's command word, runs one transaction on a single-target valid/ready bus, and waits for the response (with timeout). It then returns the response to the winner and pulses `ack` so the arbiter advances its rotation pointer.

## Interface
- `N`, 2: number of requesters; must match the arbiter.
- `DW`, 8: command and response data width.
- `TIMEOUT`, 15: maximum response wait in cycles (≥1).
- `IW`, max(1,$clog2(N)): requester index width (derived).
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset rst, synchronous, active-high.
- `grant` in N: one-hot grant from the arbiter (combinational there).
- `req_data` in N*DW: flattened command words; requester i at [i*DW +: DW].
- `ack` out 1: one-cycle completion pulse to the arbiter; its falling edge advances the arbiter.
- `busy` out 1: high whenever the state is not IDLE.
- `bus_valid` out 1: command valid to target.
- `bus_ready` in 1: target accepts command.
- `bus_id` out IW: index of the requester being served.
- `bus_wdata` out DW: captured command word.
- `rsp_valid` in 1: target response valid (single-cycle).
- `rsp_data` in DW: target response data.
- `done` out N: one-hot completion pulse to the served requester.
- `done_data` out DW: response returned with `done`.
- `timeout` out 1: qualifies `done`; response missing.
- `grant_err` out 1: sticky; set when `grant` is seen with more than one bit set.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, ACK.
- IDLE: when `grant != 0`, priority-encode the grant (lowest index wins) into `idx`. Latch `idx` into `bus_id` and `req_data[idx]` into `bus_wdata`, then go to ISSUE. If `grant` has more than one bit set, also set `grant_err` (cleared only by `rst`).
- ISSUE: `bus_valid=1`, and `bus_id`/`bus_wdata` stay stable. On `bus_valid && bus_ready`, go to WAIT_RSP and clear the timeout counter. There is no timeout in ISSUE.
- WAIT_RSP:
  - If `rsp_valid`, latch `rsp_data` into `done_data`, set `timeout=0`, go to ACK.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no response, set `done_data=0` and `timeout=1`, then go to ACK.
  - `rsp_valid` in the expiry cycle wins: the response is taken and `timeout=0`.
- ACK: `ack=1` and `done[bus_id]=1` for exactly one cycle, with `done_data` and `timeout` valid. Go to IDLE unconditionally.
- Changes in `grant`, `req_data` or requester `req` after capture are ignored until the next IDLE.
- `rsp_valid` outside WAIT_RSP is ignored.
- Counter width: $clog2(TIMEOUT+1).

## Timing
- Reset values: state IDLE; `ack`, `busy`, `bus_valid`, `done`, `timeout`, `grant_err` = 0; `bus_id`, `bus_wdata`, `done_data` = 0.
- `rst` mid-transaction returns to IDLE on that edge. It produces no `ack` or `done` pulse; `bus_valid` drops the next cycle.
- Grant sampled at edge E0 gives `bus_valid` high in cycle E0+1.
- With `bus_ready` already high, WAIT_RSP starts in cycle E0+2.
- A response in WAIT_RSP cycle k gives ACK (`ack`/`done`) in cycle k+1.
- Minimum service time (`bus_ready`=1, response in the first WAIT_RSP cycle) is 4 cycles from grant sample to the end of ACK.
- Timeout: with no response, ACK occurs in the cycle TIMEOUT+1 after entering WAIT_RSP.
- `ack` falls on the edge leaving ACK. The arbiter's grant settles during the following IDLE cycle and is sampled at the end of it. Back-to-back service therefore has one IDLE cycle between ACK and the next ISSUE.
- Outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Test plan
- **Single request:** N=2, grant=01, req_data[0]=0xA5, bus_ready=1, rsp_valid with 0x3C in the 1st WAIT_RSP cycle. Expect:
  - `bus_valid` for 1 cycle with bus_wdata=0xA5, bus_id=0.
  - Then ack=1, done=01, done_data=0x3C, timeout=0 in the same cycle.
- **Backpressure:** bus_ready low for 5 cycles. Expect `bus_valid` held for 6 cycles with stable data, and no timeout counting.
- **Timeout:** TIMEOUT=15, no rsp_valid. Expect ACK in the 16th cycle after WAIT_RSP entry, with done pulse, timeout=1, done_data=0.
  - Repeat with rsp_valid in the 15th WAIT_RSP cycle: expect timeout=0 and the data taken.
- **Round-robin loop with arbiter:** both req held high. Expect grants alternating 01,10,01 across successive acks, with exactly one IDLE cycle between ACK and the next ISSUE.
- **Reset mid-WAIT_RSP:** assert rst for 1 cycle. Expect IDLE, all outputs 0, no ack/done pulse, and a stray rsp_valid afterwards ignored.
- **Illegal grant:** force grant=11. Expect requester 0 served and grant_err=1 sticky until rst.
